fmc_adc_lvds_stim: RTL and testbench
====================================

Name: fmc_adc_lvds_stim

Overview:
- Parametrised RTL stimulus model of the FMC ADC serial LVDS interface (DCO, FR, per-channel data lanes). Used in the SPEC top-level bench in place of hand-toggled DCO/FR and tied-off data.
- Generalises that stimulus in three ways: channel count, lanes per channel, and bits per lane are parameters; data comes from constant, ramp or external sample sources.
- Runs from one bit-rate clock. Data and DCO are edge-aligned; the bench adds any skew.

Parameters:
- g_nchan, 4, number of ADC channels.
- g_lanes, 2, serial lanes per channel (1 or 2).
- g_bits_per_lane, 8, bits per lane per frame (F); must be even.
- g_sample_width, 14, sample width S; S <= g_lanes*F.

Ports:
- clk_i  in  1  bit clock (one serial bit per cycle).
- rst_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  run enable.
- mode_i  in  2  source select: 0 constant, 1 ramp, 2 external, 3 reserved.
- const_i  in  S  constant sample, applied to all channels.
- sample_i  in  g_nchan*S  external samples; channel c is at [c*S +: S].
- sample_valid_i  in  1  external sample valid.
- sample_ready_o  out  1  external sample accept strobe.
- dco_o  out  1  data clock; toggles every cycle in RUN.
- fr_o  out  1  frame clock.
- out_o  out  g_nchan*g_lanes  serial data; lane l of channel c is bit c*g_lanes+l.
- frame_cnt_o  out  32  frames emitted since entering RUN.
- underrun_o  out  1  sticky: external mode lacked valid at a frame load.

Behaviour:
- Reset (async, immediate, including mid-frame): state IDLE. All outputs 0, bit_cnt 0, ramp counters 0, held samples 0.
- FSM IDLE -> RUN: en_i=1 sampled in IDLE.
  - Cycle of transition: frame word loaded and frame_cnt_o cleared to 0.
  - Next cycle: bit 0 of the first frame on out_o, dco_o=1, fr_o=1.
- FSM RUN -> IDLE: only at the last bit of a frame (bit_cnt=F-1) with en_i=0. Frames are never truncated. Next cycle all outputs are 0 and underrun_o is cleared.
- bit_cnt runs 0..F-1 and wraps.
  - fr_o=1 for bit_cnt<F/2, else 0.
  - dco_o inverts every RUN cycle, so the first bit sees dco_o=1.
- Frame word per channel:
  - Sample is left-justified in W=g_lanes*F bits (sample << (W-S)).
  - Lane l carries word bits with index mod g_lanes == g_lanes-1-l, MSB first.
  - Example g_lanes=2, F=8: lane 0 = bits 15,13..1; lane 1 = bits 14,12..0.
- Load point: the cycle with bit_cnt=F-1, plus the IDLE->RUN cycle. mode_i and const_i are sampled only at load points; mode changes mid-frame take effect at the next frame.
- Mode 1 (ramp): one counter per channel, all start at 0. The counter value is loaded, then incremented mod 2^S. First frame = 0.
- Mode 2 (external):
  - sample_ready_o=1 exactly on load-point cycles while in RUN or entering RUN.
  - Transfer occurs when sample_valid_i=1 on that cycle; samples are latched.
  - No valid: previous held samples are repeated and underrun_o is set (sticky until return to IDLE).
- Mode 3: treated as mode 0 unless the optional feature is enabled.
- frame_cnt_o increments at each load point after the first, wrapping 2^32-1 -> 0.

Optional Feature:
- Macro FMC_ADC_LVDS_STIM_TESTPAT_EN.
- Defined: mode 3 emits a checkerboard on all channels, alternating per frame: first frame all-bits 0b1010... (S=14: 0x2AAA), next 0x1555, and so on. Phase resets on entry to RUN.
- Undefined: mode 3 behaves exactly as mode 0. No extra registers are synthesised.

Test Plan:
- Defaults, mode 0, const_i=0x0000, en_i=1 for 40 cycles -> dco_o toggles each cycle. fr_o pattern 1111 0000 repeats. out_o all 0. frame_cnt_o reaches 4 after 5 frames.
- Mode 0, const_i=0x3FFF -> word 0xFFFC. Lane 0 = 1111 1110, lane 1 = 1111 1110 on every channel.
- Mode 1, 300 frames -> deserialised channel values 0,1,2,... and wrap 16383 -> 0 at frame 16384. Check the wrap separately with S=4: 15 -> 0 at frame 16.
- Mode 2 with valid asserted only on alternate load points -> ready pulses exactly at bit_cnt=7. Missing-valid frames repeat the prior samples. underrun_o=1 after the first miss.
- en_i dropped at bit_cnt=3 -> frame completes (bits 4..7 emitted), then outputs go to 0. underrun_o clears. Re-enable restarts frame_cnt_o at 0.
- rst_n_i asserted at bit_cnt=5 -> all outputs 0 in the same cycle (async). With FMC_ADC_LVDS_STIM_TESTPAT_EN, mode 3 deserialises as 0x2AAA, 0x1555, 0x2AAA.

Source files
------------

// File: rtl/fmc_adc_lvds_stim.sv
// fmc_adc_lvds_stim
// RTL stimulus model of an FMC ADC serial LVDS interface: DCO, FR and
// per-channel data lanes, all produced from a single bit-rate clock.
// Data and DCO are edge-aligned; any skew is added by the surrounding bench.
//
// Sample sources (mode_i): 0 constant, 1 ramp, 2 external handshake,
// 3 checkerboard test pattern when FMC_ADC_LVDS_STIM_TESTPAT_EN is defined,
// otherwise identical to mode 0.
module fmc_adc_lvds_stim #(
  parameter int g_nchan         = 4,
  parameter int g_lanes         = 2,
  parameter int g_bits_per_lane = 8,
  parameter int g_sample_width  = 14
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                en_i,
  input  logic [1:0]                          mode_i,
  input  logic [g_sample_width-1:0]           const_i,
  input  logic [g_nchan*g_sample_width-1:0]   sample_i,
  input  logic                                sample_valid_i,
  output logic                                sample_ready_o,
  output logic                                dco_o,
  output logic                                fr_o,
  output logic [g_nchan*g_lanes-1:0]          out_o,
  output logic [31:0]                         frame_cnt_o,
  output logic                                underrun_o
);

  localparam int F   = g_bits_per_lane;
  localparam int S   = g_sample_width;
  localparam int W   = g_lanes * g_bits_per_lane;
  localparam int BCW = (F > 1) ? $clog2(F) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t         state_reg;
  logic [BCW-1:0] bit_cnt_reg;
  logic           dco_reg;
  logic           fr_reg;
  logic [31:0]    frame_cnt_reg;
  logic           underrun_reg;

  logic entering;
  logic last_bit;
  logic load_now;
  logic ext_mode;

  genvar gi;

  // A frame word is loaded either on the enable cycle in IDLE or on the
  // last bit of a running frame when the run continues.
  assign entering = (state_reg == ST_IDLE) && en_i;
  assign last_bit = (state_reg == ST_RUN) && (bit_cnt_reg == BCW'(F - 1));
  assign load_now = entering || (last_bit && en_i);
  assign ext_mode = (mode_i == 2'd2);

  // Ready marks the only cycles on which an external sample set is taken.
  assign sample_ready_o = rst_n_i && load_now && ext_mode;

  assign dco_o       = dco_reg;
  assign fr_o        = fr_reg;
  assign frame_cnt_o = frame_cnt_reg;
  assign underrun_o  = underrun_reg;

`ifdef FMC_ADC_LVDS_STIM_TESTPAT_EN
  logic         pat_phase_reg;
  logic         pat_phase;
  logic [S-1:0] pat_word;

  // Phase 0 gives ...1010 (odd bits set); the first frame after entry uses phase 0.
  assign pat_phase = entering ? 1'b0 : pat_phase_reg;
  for (gi = 0; gi < S; gi++) begin : g_pat
    assign pat_word[gi] = ((gi % 2) == 1) ^ pat_phase;
  end

  // Checkerboard phase flips on every loaded frame and restarts on entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pat_phase_reg <= 1'b0;
    end else if (entering) begin
      pat_phase_reg <= 1'b1;
    end else if (load_now) begin
      pat_phase_reg <= ~pat_phase_reg;
    end
  end
`endif

  // Frame sequencer: bit counter, DCO/FR generation, frame count, underrun flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      dco_reg       <= 1'b0;
      fr_reg        <= 1'b0;
      frame_cnt_reg <= '0;
      underrun_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          bit_cnt_reg   <= '0;
          frame_cnt_reg <= '0;
          if (en_i) begin
            state_reg    <= ST_RUN;
            dco_reg      <= 1'b1;
            fr_reg       <= 1'b1;
            underrun_reg <= ext_mode && !sample_valid_i;
          end else begin
            dco_reg      <= 1'b0;
            fr_reg       <= 1'b0;
            underrun_reg <= 1'b0;
          end
        end
        ST_RUN: begin
          if (last_bit) begin
            bit_cnt_reg <= '0;
            if (en_i) begin
              dco_reg       <= ~dco_reg;
              fr_reg        <= 1'b1;
              frame_cnt_reg <= frame_cnt_reg + 32'd1;
              underrun_reg  <= underrun_reg | (ext_mode && !sample_valid_i);
            end else begin
              // Run ends only on a frame boundary; everything returns to zero.
              state_reg     <= ST_IDLE;
              dco_reg       <= 1'b0;
              fr_reg        <= 1'b0;
              frame_cnt_reg <= '0;
              underrun_reg  <= 1'b0;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + BCW'(1);
            dco_reg     <= ~dco_reg;
            fr_reg      <= (bit_cnt_reg + BCW'(1)) < BCW'(F / 2);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  for (gi = 0; gi < g_nchan; gi++) begin : g_chan
    logic [S-1:0]       held_reg;
    logic [S-1:0]       ramp_reg;
    logic [S-1:0]       ext_sample;
    logic [S-1:0]       sel_sample;
    logic [W-1:0]       word;
    logic [W-1:0]       sh_reg;
    logic [g_lanes-1:0] lane_reg;

    assign ext_sample = sample_i[gi*S +: S];

    // Source select and left-justification of the sample into the frame word.
    always_comb begin
      sel_sample = const_i;
      case (mode_i)
        2'd1:    sel_sample = ramp_reg;
        2'd2:    sel_sample = sample_valid_i ? ext_sample : held_reg;
`ifdef FMC_ADC_LVDS_STIM_TESTPAT_EN
        2'd3:    sel_sample = pat_word;
`endif
        default: sel_sample = const_i;
      endcase
      word = W'(sel_sample) << (W - S);
    end

    // Serialiser: each cycle the top g_lanes bits go out, lane 0 taking the MSB.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        held_reg <= '0;
        ramp_reg <= '0;
        sh_reg   <= '0;
        lane_reg <= '0;
      end else begin
        if (load_now) begin
          for (int l = 0; l < g_lanes; l++) lane_reg[l] <= word[W-1-l];
          sh_reg <= word << g_lanes;
          if (mode_i == 2'd1) ramp_reg <= ramp_reg + S'(1);
        end else if ((state_reg == ST_RUN) && !last_bit) begin
          for (int l = 0; l < g_lanes; l++) lane_reg[l] <= sh_reg[W-1-l];
          sh_reg <= sh_reg << g_lanes;
        end else begin
          lane_reg <= '0;
          sh_reg   <= '0;
        end
        if (load_now && ext_mode && sample_valid_i) held_reg <= ext_sample;
      end
    end

    assign out_o[gi*g_lanes +: g_lanes] = lane_reg;
  end

endmodule

// File: tb/tb_fmc_adc_lvds_stim.sv
// tb_fmc_adc_lvds_stim
// Frame-level bench: table of per-frame stimulus/expected samples applied
// back to back, then directed sequences for enable drop, async reset and a
// narrow-sample ramp wrap on a second instance.
// Checks mode 3 as a checkerboard when FMC_ADC_LVDS_STIM_TESTPAT_EN is defined.
module tb_fmc_adc_lvds_stim;

  localparam int NCH = 4;
  localparam int L   = 2;
  localparam int F   = 8;
  localparam int S   = 14;
  localparam int W   = L * F;
  localparam int NV  = 14;
  localparam int S2  = 4;

`ifdef FMC_ADC_LVDS_STIM_TESTPAT_EN
  localparam logic [S-1:0] M3_A = 14'h2AAA;
  localparam logic [S-1:0] M3_B = 14'h1555;
`else
  localparam logic [S-1:0] M3_A = 14'h0ABC;
  localparam logic [S-1:0] M3_B = 14'h0ABC;
`endif

  typedef struct packed {
    logic [1:0]       mode;
    logic [S-1:0]     cval;
    logic             valid;
    logic [NCH*S-1:0] ext;
    logic [NCH*S-1:0] exp;
    logic             und;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [S-1:0]     cval;
  logic [NCH*S-1:0] smp;
  logic             valid;
  logic             ready;
  logic             dco;
  logic             fr;
  logic [NCH*L-1:0] dout;
  logic [31:0]      fcnt;
  logic             und;

  logic             en2;
  logic [1:0]       mode2;
  logic [S2-1:0]    cval2;
  logic [S2-1:0]    smp2;
  logic             valid2;
  logic             ready2;
  logic             dco2;
  logic             fr2;
  logic [L-1:0]     dout2;
  logic [31:0]      fcnt2;
  logic             und2;

  int n_vec = 0;
  int n_err = 0;

  vec_t             vecs [NV];
  logic [NCH*S-1:0] got;

  always #5 clk = ~clk;

  fmc_adc_lvds_stim #(
    .g_nchan(NCH), .g_lanes(L), .g_bits_per_lane(F), .g_sample_width(S)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .mode_i(mode), .const_i(cval),
    .sample_i(smp), .sample_valid_i(valid), .sample_ready_o(ready),
    .dco_o(dco), .fr_o(fr), .out_o(dout), .frame_cnt_o(fcnt), .underrun_o(und)
  );

  fmc_adc_lvds_stim #(
    .g_nchan(1), .g_lanes(L), .g_bits_per_lane(F), .g_sample_width(S2)
  ) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en2), .mode_i(mode2), .const_i(cval2),
    .sample_i(smp2), .sample_valid_i(valid2), .sample_ready_o(ready2),
    .dco_o(dco2), .fr_o(fr2), .out_o(dout2), .frame_cnt_o(fcnt2), .underrun_o(und2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] m, input logic [S-1:0] c, input logic vl,
                              input logic [NCH*S-1:0] x, input logic [NCH*S-1:0] e,
                              input logic u);
    vec_t r;
    r.mode  = m;
    r.cval  = c;
    r.valid = vl;
    r.ext   = x;
    r.exp   = e;
    r.und   = u;
    return r;
  endfunction

  task automatic apply(input vec_t v);
    mode  = v.mode;
    cval  = v.cval;
    valid = v.valid;
    smp   = v.ext;
  endtask

  // Captures one frame from dut, checking strobes bit by bit; returns at the
  // negedge of the last bit so the caller can set up the next load.
  task automatic run_frame(input logic [31:0] exp_fc, input logic exp_und,
                           input int drop_k, output logic [NCH*S-1:0] smp_out);
    logic [W-1:0] wd [NCH];
    for (int c = 0; c < NCH; c++) wd[c] = '0;
    for (int k = 0; k < F; k++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++)
        for (int l = 0; l < L; l++)
          wd[c][W-1-k*L-l] = dout[c*L+l];
      check($sformatf("dco[k=%0d]", k), 64'(dco), 64'(k % 2 == 0));
      check($sformatf("fr[k=%0d]", k), 64'(fr), 64'(k < F / 2));
      if (k == 0) begin
        check("frame_cnt", 64'(fcnt), 64'(exp_fc));
        check("underrun", 64'(und), 64'(exp_und));
      end
      if (k < F - 1) check($sformatf("ready_midframe[k=%0d]", k), 64'(ready), 64'd0);
      if (k == drop_k) en = 1'b0;
    end
    for (int c = 0; c < NCH; c++) smp_out[c*S +: S] = wd[c][W-1 -: S];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  wd2;
    logic [S2-1:0] r2;

    vecs[0]  = mk(2'd0, 14'h0000, 1'b0, '0, {4{14'h0000}}, 1'b0);
    vecs[1]  = mk(2'd0, 14'h3FFF, 1'b0, '0, {4{14'h3FFF}}, 1'b0);
    vecs[2]  = mk(2'd0, 14'h1234, 1'b0, '0, {4{14'h1234}}, 1'b0);
    vecs[3]  = mk(2'd1, 14'h0555, 1'b0, '0, {4{14'h0000}}, 1'b0);
    vecs[4]  = mk(2'd1, 14'h0555, 1'b0, '0, {4{14'h0001}}, 1'b0);
    vecs[5]  = mk(2'd1, 14'h0555, 1'b0, '0, {4{14'h0002}}, 1'b0);
    vecs[6]  = mk(2'd2, 14'h0000, 1'b1, {14'h3ABC, 14'h2789, 14'h1456, 14'h0123},
                  {14'h3ABC, 14'h2789, 14'h1456, 14'h0123}, 1'b0);
    vecs[7]  = mk(2'd2, 14'h0000, 1'b0, {14'h0001, 14'h0002, 14'h0003, 14'h0004},
                  {14'h3ABC, 14'h2789, 14'h1456, 14'h0123}, 1'b1);
    vecs[8]  = mk(2'd2, 14'h0000, 1'b1, {14'h0F0F, 14'h3000, 14'h00FF, 14'h1111},
                  {14'h0F0F, 14'h3000, 14'h00FF, 14'h1111}, 1'b1);
    vecs[9]  = mk(2'd2, 14'h0000, 1'b0, {4{14'h3FFF}},
                  {14'h0F0F, 14'h3000, 14'h00FF, 14'h1111}, 1'b1);
    vecs[10] = mk(2'd3, 14'h0ABC, 1'b0, '0, {4{M3_A}}, 1'b1);
    vecs[11] = mk(2'd3, 14'h0ABC, 1'b0, '0, {4{M3_B}}, 1'b1);
    vecs[12] = mk(2'd3, 14'h0ABC, 1'b0, '0, {4{M3_A}}, 1'b1);
    vecs[13] = mk(2'd0, 14'h2001, 1'b0, '0, {4{14'h2001}}, 1'b1);

    rst_n = 1'b0; en = 1'b0; mode = 2'd0; cval = '0; smp = '0; valid = 1'b0;
    en2 = 1'b0; mode2 = 2'd1; cval2 = '0; smp2 = '0; valid2 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out", 64'(dout), 64'd0);
    check("rst_dco", 64'(dco), 64'd0);
    check("rst_fr", 64'(fr), 64'd0);
    check("rst_frame_cnt", 64'(fcnt), 64'd0);
    check("rst_underrun", 64'(und), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_out", 64'(dout), 64'd0);
    check("idle_dco", 64'(dco), 64'd0);

    // Table: one record per frame, run back to back with en held high
    en = 1'b1;
    apply(vecs[0]);
    #1 check("ready_load0", 64'(ready), 64'(vecs[0].mode == 2'd2));
    for (int v = 0; v < NV; v++) begin
      run_frame(32'(v), vecs[v].und, -1, got);
      check($sformatf("samples[v=%0d]", v), 64'(got), 64'(vecs[v].exp));
      $display("frame %0d mode %0d samples %h underrun %b", v, vecs[v].mode, got, und);
      if (v < NV - 1) begin
        apply(vecs[v+1]);
        #1 check($sformatf("ready_load[v=%0d]", v + 1), 64'(ready), 64'(vecs[v+1].mode == 2'd2));
      end else begin
        en = 1'b0;
        #1 check("ready_exit", 64'(ready), 64'd0);
      end
    end
    @(negedge clk);
    check("exit_out", 64'(dout), 64'd0);
    check("exit_dco", 64'(dco), 64'd0);
    check("exit_fr", 64'(fr), 64'd0);
    check("exit_frame_cnt", 64'(fcnt), 64'd0);
    check("exit_underrun_clr", 64'(und), 64'd0);

    // Enable dropped mid-frame: frame completes, then idle, then restart
    en = 1'b1;
    apply(mk(2'd0, 14'h3FFF, 1'b0, '0, '0, 1'b0));
    #1;
    run_frame(32'd0, 1'b0, -1, got);
    check("drop_f0", 64'(got), 64'({4{14'h3FFF}}));
    run_frame(32'd1, 1'b0, -1, got);
    check("drop_f1", 64'(got), 64'({4{14'h3FFF}}));
    run_frame(32'd2, 1'b0, 3, got);
    check("drop_f2_complete", 64'(got), 64'({4{14'h3FFF}}));
    $display("enable dropped at bit 3, frame samples %h", got);
    #1 check("drop_ready", 64'(ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("drop_idle_out[%0d]", i), 64'(dout), 64'd0);
      check($sformatf("drop_idle_dco[%0d]", i), 64'(dco), 64'd0);
      check($sformatf("drop_idle_fcnt[%0d]", i), 64'(fcnt), 64'd0);
    end
    en = 1'b1;
    #1;
    run_frame(32'd0, 1'b0, -1, got);
    check("reen_f0", 64'(got), 64'({4{14'h3FFF}}));
    run_frame(32'd1, 1'b0, -1, got);
    check("reen_f1", 64'(got), 64'({4{14'h3FFF}}));
    $display("re-enabled, frame_cnt restarted, samples %h", got);

    // Async reset at bit 5 of the third frame
    for (int k = 0; k <= 5; k++) @(negedge clk);
    check("pre_rst_out", 64'(dout), 64'hFF);
    check("pre_rst_fcnt", 64'(fcnt), 64'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 64'(dout), 64'd0);
    check("async_rst_dco", 64'(dco), 64'd0);
    check("async_rst_fr", 64'(fr), 64'd0);
    check("async_rst_fcnt", 64'(fcnt), 64'd0);
    check("async_rst_ready", 64'(ready), 64'd0);
    $display("async reset at bit 5, out %h frame_cnt %0d", dout, fcnt);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out", 64'(dout), 64'd0);
    check("post_rst_dco", 64'(dco), 64'd0);

    // Ramp wrap on a 4-bit instance: 15 -> 0 at frame 16
    en2 = 1'b1;
    for (int f = 0; f < 17; f++) begin
      wd2 = '0;
      for (int k = 0; k < F; k++) begin
        @(negedge clk);
        for (int l = 0; l < L; l++) wd2[W-1-k*L-l] = dout2[l];
        if (k == 0) check($sformatf("ramp4_fcnt[f=%0d]", f), 64'(fcnt2), 64'(f));
      end
      r2 = wd2[W-1 -: S2];
      check($sformatf("ramp4[f=%0d]", f), 64'(r2), 64'(f % 16));
      $display("ramp4 frame %0d value %0d", f, r2);
    end
    en2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
